ped_serial_metric: RTL and testbench

//  Next-generation partial-Euclidean-distance engine for the sphere-decoder tree search.

---
 rtl/ped_serial_metric.sv | 204 ++++++++++++++++++++
 tb/tb_ped_serial_metric.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_serial_metric.sv
// Serial partial-Euclidean-distance engine: accumulates R(i,j)*s(j) terms, then
// forms PED = parent + |y - sum|^2 with rounding, saturation and handshakes.
//
// state | meaning
// IDLE  | waiting for start handshake, o_ready high
// ACC   | accepting terms, one registered complex product per accept
// DRAIN | final registered product folded into the accumulator
// DIFF  | err <= sat(y - acc)
// SQR   | ped <= sat(parent + rnd(|err|^2))
// OUT   | result presented until downstream accepts
module ped_serial_metric #(
   parameter int INT_W     = 6,
   parameter int FRAC_W    = 10,
   parameter int WIDTH     = INT_W + FRAC_W,
   parameter int MAX_TERMS = 4,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1),
   parameter int ACC_GUARD = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_start,
   output logic                 o_ready,
   input  logic [2*WIDTH-1:0]   i_y,
   input  logic [WIDTH-1:0]     i_ped_parent,
   input  logic [CNT_W-1:0]     i_num_terms,
   input  logic                 i_term_valid,
   output logic                 o_term_ready,
   input  logic [2*WIDTH-1:0]   i_r,
   input  logic [2*WIDTH-1:0]   i_s,
   output logic                 o_valid,
   input  logic                 i_out_ready,
   output logic [WIDTH-1:0]     o_ped,
   output logic                 o_overflow
);

   localparam int ACC_W = WIDTH + ACC_GUARD;
   localparam int EXT_W = 2*WIDTH + 1;
   localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (FRAC_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ACC   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_DIFF  = 3'd3;
   localparam logic [2:0] S_SQR   = 3'd4;
   localparam logic [2:0] S_OUT   = 3'd5;

   // Returns {saturated, value}; in range when all bits above the WIDTH-1 sign agree.
   function automatic logic [WIDTH:0] sat_s(input logic [EXT_W-1:0] v);
      if (&v[EXT_W-1:WIDTH-1] || ~|v[EXT_W-1:WIDTH-1])
         return {1'b0, v[WIDTH-1:0]};
      else if (v[EXT_W-1])
         return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   function automatic logic [WIDTH:0] mul_rnd(input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
      logic signed [2*WIDTH-1:0] p;
      logic [EXT_W-1:0]          sum;
      p   = a * b;
      sum = {p[2*WIDTH-1], p} + HALF;
      return sat_s(EXT_W'($signed(sum) >>> FRAC_W));
   endfunction

   logic [2:0]               state;
   logic [CNT_W-1:0]         rem;
   logic [2*WIDTH-1:0]       y_lat;
   logic [WIDTH-1:0]         parent;
   logic [WIDTH:0]           prod_re, prod_im;
   logic                     prod_vld;
   logic [ACC_W-1:0]         acc_re, acc_im;
   logic signed [WIDTH-1:0]  err_re, err_im;
   logic [WIDTH-1:0]         ped;
   logic                     ovf;

   logic signed [WIDTH-1:0]  r_re, r_im, s_re, s_im;
   logic [WIDTH:0]           m_ac, m_bd, m_ad, m_bc;
   logic [WIDTH:0]           c_re, c_im;
   logic                     mul_ovf;
   logic [ACC_W-1:0]         acc_re_nxt, acc_im_nxt;
   logic [EXT_W-1:0]         d_re, d_im;
   logic [WIDTH:0]           ds_re, ds_im;
   logic [2*WIDTH-1:0]       sq_re, sq_im;
   logic [EXT_W-1:0]         sq_sum, sq_rnd, ped_sum;
   logic                     ped_ovf;
   logic [WIDTH-1:0]         ped_val;
   logic [CNT_W-1:0]         n_clamp;
   logic                     term_acc;

   assign r_re = i_r[2*WIDTH-1:WIDTH];
   assign r_im = i_r[WIDTH-1:0];
   assign s_re = i_s[2*WIDTH-1:WIDTH];
   assign s_im = i_s[WIDTH-1:0];

   assign m_ac = mul_rnd(r_re, s_re);
   assign m_bd = mul_rnd(r_im, s_im);
   assign m_ad = mul_rnd(r_re, s_im);
   assign m_bc = mul_rnd(r_im, s_re);

   // Complex components kept one bit wider so ac-bd / ad+bc never wrap.
   assign c_re = {m_ac[WIDTH-1], m_ac[WIDTH-1:0]} - {m_bd[WIDTH-1], m_bd[WIDTH-1:0]};
   assign c_im = {m_ad[WIDTH-1], m_ad[WIDTH-1:0]} + {m_bc[WIDTH-1], m_bc[WIDTH-1:0]};
   assign mul_ovf = m_ac[WIDTH] | m_bd[WIDTH] | m_ad[WIDTH] | m_bc[WIDTH];

   assign acc_re_nxt = acc_re + {{(ACC_W-WIDTH-1){prod_re[WIDTH]}}, prod_re};
   assign acc_im_nxt = acc_im + {{(ACC_W-WIDTH-1){prod_im[WIDTH]}}, prod_im};

   assign d_re = {{(EXT_W-WIDTH){y_lat[2*WIDTH-1]}}, y_lat[2*WIDTH-1:WIDTH]}
               - {{(EXT_W-ACC_W){acc_re[ACC_W-1]}}, acc_re};
   assign d_im = {{(EXT_W-WIDTH){y_lat[WIDTH-1]}}, y_lat[WIDTH-1:0]}
               - {{(EXT_W-ACC_W){acc_im[ACC_W-1]}}, acc_im};
   assign ds_re = sat_s(d_re);
   assign ds_im = sat_s(d_im);

   assign sq_re   = err_re * err_re;
   assign sq_im   = err_im * err_im;
   assign sq_sum  = {1'b0, sq_re} + {1'b0, sq_im};
   assign sq_rnd  = (sq_sum + HALF) >> FRAC_W;
   assign ped_sum = {{(EXT_W-WIDTH){1'b0}}, parent} + sq_rnd;
   assign ped_ovf = |ped_sum[EXT_W-1:WIDTH];
   assign ped_val = ped_ovf ? {WIDTH{1'b1}} : ped_sum[WIDTH-1:0];

   assign n_clamp  = (i_num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : i_num_terms;
   assign term_acc = i_term_valid && (state == S_ACC);

   assign o_ready      = (state == S_IDLE);
   assign o_term_ready = (state == S_ACC);
   assign o_valid      = (state == S_OUT);
   assign o_ped        = ped;
   assign o_overflow   = ovf;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         rem      <= '0;
         y_lat    <= '0;
         parent   <= '0;
         prod_re  <= '0;
         prod_im  <= '0;
         prod_vld <= 1'b0;
         acc_re   <= '0;
         acc_im   <= '0;
         err_re   <= '0;
         err_im   <= '0;
         ped      <= '0;
         ovf      <= 1'b0;
      end else if (i_flush) begin
         state    <= S_IDLE;
         prod_vld <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (i_start) begin
               y_lat    <= i_y;
               parent   <= i_ped_parent;
               rem      <= n_clamp;
               acc_re   <= '0;
               acc_im   <= '0;
               prod_vld <= 1'b0;
               ovf      <= 1'b0;
               state    <= (n_clamp != '0) ? S_ACC : S_DIFF;
            end
            S_ACC: begin
               if (prod_vld) begin
                  acc_re <= acc_re_nxt;
                  acc_im <= acc_im_nxt;
               end
               prod_vld <= term_acc;
               if (term_acc) begin
                  prod_re <= c_re;
                  prod_im <= c_im;
                  ovf     <= ovf | mul_ovf;
                  rem     <= rem - 1'b1;
                  if (rem == CNT_W'(1)) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (prod_vld) begin
                  acc_re <= acc_re_nxt;
                  acc_im <= acc_im_nxt;
               end
               prod_vld <= 1'b0;
               state    <= S_DIFF;
            end
            S_DIFF: begin
               err_re <= ds_re[WIDTH-1:0];
               err_im <= ds_im[WIDTH-1:0];
               ovf    <= ovf | ds_re[WIDTH] | ds_im[WIDTH];
               state  <= S_SQR;
            end
            S_SQR: begin
               ped   <= ped_val;
               ovf   <= ovf | ped_ovf;
               state <= S_OUT;
            end
            S_OUT: if (i_out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ped_serial_metric.sv
// Bench for ped_serial_metric: directed cases plus randomized operations checked
// against an integer-arithmetic reference of the PED computation.
module tb_ped_serial_metric;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_start = 1'b0;
   logic        o_ready;
   logic [31:0] i_y = '0;
   logic [15:0] i_ped_parent = '0;
   logic [2:0]  i_num_terms = '0;
   logic        i_term_valid = 1'b0;
   logic        o_term_ready;
   logic [31:0] i_r = '0;
   logic [31:0] i_s = '0;
   logic        o_valid;
   logic        i_out_ready = 1'b0;
   logic [15:0] o_ped;
   logic        o_overflow;

   ped_serial_metric dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_start(i_start),
      .o_ready(o_ready), .i_y(i_y), .i_ped_parent(i_ped_parent),
      .i_num_terms(i_num_terms), .i_term_valid(i_term_valid),
      .o_term_ready(o_term_ready), .i_r(i_r), .i_s(i_s), .o_valid(o_valid),
      .i_out_ready(i_out_ready), .o_ped(o_ped), .o_overflow(o_overflow)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [31:0] r_arr[4];
   logic [31:0] s_arr[4];
   int gap[4];
   bit m_ovf;
   bit saw_term_ready;

   // ---------------- reference model ----------------
   function automatic longint sx(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint rnd(input longint p);
      return (p + 512) >>> 10;
   endfunction

   function automatic longint sat16(input longint v);
      if (v > 32767) begin m_ovf = 1'b1; return 32767; end
      if (v < -32768) begin m_ovf = 1'b1; return -32768; end
      return v;
   endfunction

   function automatic longint wrap18(input longint v);
      longint w;
      w = v % 262144;
      if (w < 0) w += 262144;
      if (w >= 131072) w -= 262144;
      return w;
   endfunction

   task automatic model(input logic [31:0] y, input logic [15:0] par, input int nt,
                        output logic [15:0] ped, output logic ovf);
      longint ar, ai, er, ei, t, a, b, c, d;
      m_ovf = 1'b0;
      ar = 0;
      ai = 0;
      for (int j = 0; j < nt; j++) begin
         a = sx(r_arr[j][31:16]); b = sx(r_arr[j][15:0]);
         c = sx(s_arr[j][31:16]); d = sx(s_arr[j][15:0]);
         ar = ar + sat16(rnd(a*c)) - sat16(rnd(b*d));
         ai = ai + sat16(rnd(a*d)) + sat16(rnd(b*c));
      end
      ar = wrap18(ar);
      ai = wrap18(ai);
      er = sat16(sx(y[31:16]) - ar);
      ei = sat16(sx(y[15:0]) - ai);
      t = longint'(par) + rnd(er*er + ei*ei);
      if (t > 65535) begin t = 65535; m_ovf = 1'b1; end
      ped = 16'(t);
      ovf = m_ovf;
   endtask

   function automatic logic [15:0] small_val();
      return 16'(int'($urandom_range(0, 4095)) - 2048);
   endfunction

   // Runs one full operation; starts and ends on a falling edge.
   task automatic do_op(input string name, input logic [31:0] y, input logic [15:0] par,
                        input logic [2:0] n, input int hold, input bit noise,
                        output logic [15:0] got_ped, output logic got_ovf);
      int nt, k, t_ref, lat, exp_lat;
      logic [15:0] exp_ped;
      logic exp_ovf;
      nt = (n > 3'd4) ? 4 : int'(n);
      exp_lat = (nt == 0) ? 3 : 4;
      model(y, par, nt, exp_ped, exp_ovf);
      k = 0;
      while (!o_ready && k < 20) begin @(negedge i_clk); k++; end
      checks++;
      if (!o_ready) begin failures++; $display("FAIL %s ready_timeout got=%b exp=1", name, o_ready); end
      i_start = 1'b1; i_y = y; i_ped_parent = par; i_num_terms = n;
      t_ref = cyc;
      @(negedge i_clk);
      i_start = noise;
      if (noise) begin i_y = $urandom; i_ped_parent = 16'($urandom); i_num_terms = 3'($urandom); end
      for (int j = 0; j < nt; j++) begin
         repeat (gap[j]) begin
            i_term_valid = 1'b0;
            if (noise) begin i_r = $urandom; i_s = $urandom; end
            @(negedge i_clk);
         end
         k = 0;
         while (!o_term_ready && k < 10) begin @(negedge i_clk); k++; end
         i_term_valid = 1'b1; i_r = r_arr[j]; i_s = s_arr[j];
         t_ref = cyc;
         @(negedge i_clk);
      end
      i_term_valid = noise;
      if (noise) begin i_r = $urandom; i_s = $urandom; end
      saw_term_ready = 1'b0;
      k = 0;
      while (!o_valid && k < 20) begin
         if (o_term_ready) saw_term_ready = 1'b1;
         @(negedge i_clk);
         k++;
      end
      lat = o_valid ? (cyc - t_ref) : -1;
      i_start = 1'b0;
      i_term_valid = 1'b0;
      checks++;
      if (lat != exp_lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
      got_ped = o_ped;
      got_ovf = o_overflow;
      checks++;
      if (got_ped !== exp_ped) begin failures++; $display("FAIL %s ped got=%h exp=%h", name, got_ped, exp_ped); end
      checks++;
      if (got_ovf !== exp_ovf) begin failures++; $display("FAIL %s ovf got=%b exp=%b", name, got_ovf, exp_ovf); end
      repeat (hold) begin
         @(negedge i_clk);
         checks++;
         if (o_valid !== 1'b1 || o_ped !== exp_ped || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s hold got=v%b/%h/r%b exp=v1/%h/r0", name, o_valid, o_ped, o_ready, exp_ped);
         end
      end
      i_out_ready = 1'b1;
      @(negedge i_clk);
      i_out_ready = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s release got=v%b/r%b exp=v0/r1", name, o_valid, o_ready);
      end
   endtask

   task automatic set_t1();
      r_arr[0] = {16'h0200, 16'h0000};
      s_arr[0] = {16'h0200, 16'h0000};
      for (int j = 0; j < 4; j++) gap[j] = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0 || o_term_ready !== 1'b0 || o_ped !== 16'h0 || o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got=v%b/t%b/%h/o%b exp=v0/t0/0000/o0", o_valid, o_term_ready, o_ped, o_overflow);
      end
      i_rst_n = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
   endtask

   task automatic test_basic();
      logic [15:0] p; logic o;
      set_t1();
      do_op("t1", {16'h0400, 16'h0000}, 16'h0000, 3'd1, 0, 1'b0, p, o);
      checks++;
      if (p !== 16'h0240 || o !== 1'b0) begin failures++; $display("FAIL t1_const got=%h/%b exp=0240/0", p, o); end
   endtask

   task automatic test_zero_terms();
      logic [15:0] p; logic o;
      do_op("t2", {16'h0200, 16'h0200}, 16'h0400, 3'd0, 0, 1'b0, p, o);
      checks++;
      if (p !== 16'h0600) begin failures++; $display("FAIL t2_const got=%h exp=0600", p); end
      checks++;
      if (saw_term_ready !== 1'b0) begin failures++; $display("FAIL t2_term_ready got=%b exp=0", saw_term_ready); end
   endtask

   task automatic test_saturation();
      logic [15:0] p; logic o;
      r_arr[0] = {16'h8400, 16'h0000};
      s_arr[0] = {16'h0400, 16'h0000};
      gap[0] = 0;
      do_op("t3", {16'h7C00, 16'h0000}, 16'h0000, 3'd1, 0, 1'b0, p, o);
      checks++;
      if (p !== 16'hFFFF || o !== 1'b1) begin failures++; $display("FAIL t3_const got=%h/%b exp=ffff/1", p, o); end
   endtask

   task automatic test_backpressure();
      logic [15:0] p; logic o;
      set_t1();
      do_op("t4", {16'h0400, 16'h0000}, 16'h0000, 3'd1, 5, 1'b0, p, o);
      checks++;
      if (p !== 16'h0240) begin failures++; $display("FAIL t4_const got=%h exp=0240", p); end
   endtask

   task automatic test_gaps();
      logic [15:0] pa, pb; logic oa, ob;
      for (int j = 0; j < 4; j++) begin
         r_arr[j] = {small_val(), small_val()};
         s_arr[j] = {small_val(), small_val()};
         gap[j] = 0;
      end
      do_op("t5_nogap", {small_val(), small_val()}, 16'h0123, 3'd4, 0, 1'b0, pa, oa);
      gap[0] = 0; gap[1] = 2; gap[2] = 1; gap[3] = 3;
      do_op("t5_gap", i_y, 16'h0123, 3'd4, 0, 1'b0, pb, ob);
      checks++;
      if (pb !== pa || ob !== oa) begin failures++; $display("FAIL t5_same got=%h exp=%h", pb, pa); end
   endtask

   task automatic test_clamp();
      logic [15:0] p; logic o;
      for (int j = 0; j < 4; j++) begin
         r_arr[j] = {small_val(), small_val()};
         s_arr[j] = {small_val(), small_val()};
         gap[j] = 0;
      end
      do_op("clamp7", {small_val(), small_val()}, 16'h0040, 3'd7, 0, 1'b0, p, o);
   endtask

   task automatic test_reset_mid();
      logic [15:0] p; logic o;
      i_start = 1'b1; i_y = 32'h0100_0100; i_ped_parent = 16'h0; i_num_terms = 3'd4;
      @(negedge i_clk);
      i_start = 1'b0; i_term_valid = 1'b1; i_r = 32'h0400_0400; i_s = 32'h0400_0000;
      @(negedge i_clk);
      i_term_valid = 1'b0;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_term_ready !== 1'b0 || o_ped !== 16'h0 || o_overflow !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL t6_reset got=v%b/t%b/%h/o%b/r%b exp=v0/t0/0000/o0/r1", o_valid, o_term_ready, o_ped, o_overflow, o_ready);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      set_t1();
      do_op("t6_rerun", {16'h0400, 16'h0000}, 16'h0000, 3'd1, 0, 1'b0, p, o);
      checks++;
      if (p !== 16'h0240) begin failures++; $display("FAIL t6_const got=%h exp=0240", p); end
   endtask

   task automatic test_flush();
      logic [15:0] p; logic o;
      int k;
      set_t1();
      do_op("fl_pre", {16'h0400, 16'h0000}, 16'h0000, 3'd1, 0, 1'b0, p, o);
      i_start = 1'b1; i_y = 32'h1234_5678; i_num_terms = 3'd4;
      @(negedge i_clk);
      i_start = 1'b0; i_term_valid = 1'b1; i_r = 32'h7FFF_7FFF; i_s = 32'h7FFF_8000;
      repeat (2) @(negedge i_clk);
      i_term_valid = 1'b0;
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      checks++;
      if (o_ready !== 1'b1 || o_term_ready !== 1'b0 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_ped !== 16'h0240) begin
         failures++;
         $display("FAIL flush_acc got=r%b/t%b/v%b/o%b/%h exp=r1/t0/v0/o0/0240", o_ready, o_term_ready, o_valid, o_overflow, o_ped);
      end
      i_start = 1'b1; i_y = {16'h7C00, 16'h0000}; i_ped_parent = 16'h0; i_num_terms = 3'd1;
      @(negedge i_clk);
      i_start = 1'b0; i_term_valid = 1'b1; i_r = {16'h8400, 16'h0000}; i_s = {16'h0400, 16'h0000};
      @(negedge i_clk);
      i_term_valid = 1'b0;
      k = 0;
      while (!o_valid && k < 20) begin @(negedge i_clk); k++; end
      checks++;
      if (o_valid !== 1'b1 || o_overflow !== 1'b1) begin
         failures++; $display("FAIL flush_pre_out got=v%b/o%b exp=v1/o1", o_valid, o_overflow);
      end
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_overflow !== 1'b0 || o_ped !== 16'hFFFF || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_out got=v%b/o%b/%h/r%b exp=v0/o0/ffff/r1", o_valid, o_overflow, o_ped, o_ready);
      end
      set_t1();
      do_op("fl_post", {16'h0400, 16'h0000}, 16'h0000, 3'd1, 0, 1'b0, p, o);
      checks++;
      if (p !== 16'h0240 || o !== 1'b0) begin failures++; $display("FAIL fl_post_const got=%h/%b exp=0240/0", p, o); end
   endtask

   task automatic test_random();
      logic [15:0] p; logic o;
      logic [31:0] y;
      logic [15:0] par;
      bit big;
      for (int it = 0; it < 40; it++) begin
         big = ($urandom_range(0, 3) == 0);
         for (int j = 0; j < 4; j++) begin
            r_arr[j] = big ? $urandom : {small_val(), small_val()};
            s_arr[j] = big ? $urandom : {small_val(), small_val()};
            gap[j] = $urandom_range(0, 2);
         end
         y = big ? $urandom : {small_val(), small_val()};
         par = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023));
         do_op("rand", y, par, 3'($urandom_range(0, 7)), $urandom_range(0, 2),
               bit'($urandom_range(0, 1)), p, o);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_terms();
      test_saturation();
      test_backpressure();
      test_gaps();
      test_clamp();
      test_reset_mid();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
